// File: rtl/uart_pkg.sv
// Shared types and limits for the UART TX arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD,
        ARB_WAIT
    } tx_arb_state_t;

    localparam int TX_ARB_MAX_REQ = 8;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after ptr, wrapping.
module uart_tx_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic [PTR_W:0]         shamt;
    logic [2*NUM_REQ-1:0]   dbl_valid;
    logic [NUM_REQ-1:0]     rot_valid;
    logic [NUM_REQ-1:0]     rot_pick;

    // Rotate so bit 0 is the index just after ptr, isolate the lowest set bit, rotate back.
    assign shamt     = {1'b0, ptr} + (PTR_W+1)'(1);
    assign dbl_valid = {valid, valid};
    assign rot_valid = NUM_REQ'(dbl_valid >> shamt);
    assign rot_pick  = rot_valid & (~rot_valid + NUM_REQ'(1));
    assign pick      = NUM_REQ'(({rot_pick, rot_pick} << shamt) >> NUM_REQ);
    assign any       = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding TX_Escape's byte/command write port.
// Optional idle-owner release is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [NUM_REQ-1:0]     REQ_VALID_I,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA_I,
    input  logic [NUM_REQ-1:0]     REQ_CMD_I,
    input  logic [NUM_REQ-1:0]     REQ_LAST_I,
    output logic [NUM_REQ-1:0]     REQ_READY_O,
    input  logic                   TX_READY_I,
    output logic                   WRITE_O,
    output logic [7:0]             DATA_SEND_O,
    output logic                   WRITE_COMMAND_O,
    output logic [7:0]             COMMAND_O,
    output logic [NUM_REQ-1:0]     GRANT_O,
    output logic                   TIMEOUT_O
);

    localparam int PTR_W = $clog2(NUM_REQ);

    tx_arb_state_t        state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [PTR_W-1:0]     ptr_reg, ptr_next;
    logic [PTR_W-1:0]     owner_reg, owner_next;
    logic                 last_reg, last_next;
    logic                 guard_reg, guard_next;
    logic                 write_reg, write_next;
    logic                 write_cmd_reg, write_cmd_next;
    logic [7:0]           data_reg, data_next;
    logic [7:0]           cmd_byte_reg, cmd_byte_next;
    logic                 timeout_reg, timeout_next;

    logic [NUM_REQ-1:0]   pick;
    logic                 any;
    logic [PTR_W-1:0]     pick_idx;
    logic                 owner_valid, owner_cmd, owner_last;
    logic [7:0]           owner_data;
    logic                 accept;
    logic                 expire;

    uart_tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid (REQ_VALID_I),
        .ptr   (ptr_reg),
        .pick  (pick),
        .any   (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    // Mux the owner's request lines using the one-hot grant.
    always_comb begin
        owner_valid = 1'b0;
        owner_cmd   = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_reg[i]) begin
                owner_valid = REQ_VALID_I[i];
                owner_cmd   = REQ_CMD_I[i];
                owner_last  = REQ_LAST_I[i];
                owner_data  = REQ_DATA_I[8*i +: 8];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign REQ_READY_O[gi] = (state_reg == ARB_HOLD) && grant_reg[gi]
                                     && REQ_VALID_I[gi] && TX_READY_I;
        end
    endgenerate

    assign accept = |REQ_READY_O;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;

    // Counts only consecutive HOLD cycles with the owner silent; any other cycle clears it.
    always_comb begin
        idle_cnt_next = '0;
        expire        = 1'b0;
        if (state_reg == ARB_HOLD && !owner_valid) begin
            if (idle_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                expire = 1'b1;
            end else begin
                idle_cnt_next = idle_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        guard_next     = 1'b0;
        write_next     = 1'b0;
        write_cmd_next = 1'b0;
        data_next      = data_reg;
        cmd_byte_next  = cmd_byte_reg;
        timeout_next   = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (any) begin
                    grant_next = pick;
                    owner_next = pick_idx;
                    state_next = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (accept) begin
                    last_next  = owner_last;
                    guard_next = 1'b1;
                    state_next = ARB_WAIT;
                    if (owner_cmd) begin
                        write_cmd_next = 1'b1;
                        cmd_byte_next  = owner_data;
                    end else begin
                        write_next = 1'b1;
                        data_next  = owner_data;
                    end
                end else if (expire) begin
                    timeout_next = 1'b1;
                    ptr_next     = owner_reg;
                    grant_next   = '0;
                    state_next   = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                // TX_READY_I is still showing the pre-write level during the strobe cycle.
                if (!guard_reg && TX_READY_I) begin
                    if (last_reg) begin
                        ptr_next   = owner_reg;
                        grant_next = '0;
                        state_next = ARB_IDLE;
                    end else begin
                        state_next = ARB_HOLD;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg     <= ARB_IDLE;
            grant_reg     <= '0;
            ptr_reg       <= PTR_W'(NUM_REQ - 1);
            owner_reg     <= '0;
            last_reg      <= 1'b0;
            guard_reg     <= 1'b0;
            write_reg     <= 1'b0;
            write_cmd_reg <= 1'b0;
            data_reg      <= '0;
            cmd_byte_reg  <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            guard_reg     <= guard_next;
            write_reg     <= write_next;
            write_cmd_reg <= write_cmd_next;
            data_reg      <= data_next;
            cmd_byte_reg  <= cmd_byte_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign WRITE_O         = write_reg;
    assign DATA_SEND_O     = data_reg;
    assign WRITE_COMMAND_O = write_cmd_reg;
    assign COMMAND_O       = cmd_byte_reg;
    assign GRANT_O         = grant_reg;
    assign TIMEOUT_O       = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; idle-owner release cases follow UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid, cmd, last, ready, grant;
    logic [8*N-1:0] data;
    logic           tx_ready, wr, wrc, to;
    logic [7:0]     dsend, cmdo;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK_I           (clk),
        .RST_I           (rst),
        .REQ_VALID_I     (valid),
        .REQ_DATA_I      (data),
        .REQ_CMD_I       (cmd),
        .REQ_LAST_I      (last),
        .REQ_READY_O     (ready),
        .TX_READY_I      (tx_ready),
        .WRITE_O         (wr),
        .DATA_SEND_O     (dsend),
        .WRITE_COMMAND_O (wrc),
        .COMMAND_O       (cmdo),
        .GRANT_O         (grant),
        .TIMEOUT_O       (to)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int dual_err = 0;
    int to_pulses = 0;
    int to_cyc = 0;
    int rdy_cnt0 = 0;
    int rdy_cnt1 = 0;
    logic [1:0] en;
    logic [1:0] acc;
    logic [9:0] q0[$];   // {cmd, last, byte}
    logic [9:0] q1[$];
    logic [8:0] slog[$]; // {cmd, byte} per strobe
    int scyc[$];
    int alog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        valid = '0; cmd = '0; last = '0; data = '0;
        if (en[0] && q0.size() > 0) begin
            valid[0] = 1'b1;
            {cmd[0], last[0], data[7:0]} = q0[0];
        end
        if (en[1] && q1.size() > 0) begin
            valid[1] = 1'b1;
            {cmd[1], last[1], data[15:8]} = q1[0];
        end
    endtask

    // One clock: observe at the falling edge, consume accepted bytes after the rising edge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        acc = valid & ready;
        if (wr && wrc) dual_err++;
        if (wr) begin slog.push_back({1'b0, dsend}); scyc.push_back(cyc_n); end
        if (wrc) begin slog.push_back({1'b1, cmdo}); scyc.push_back(cyc_n); end
        if (to) begin to_pulses++; to_cyc = cyc_n; end
        if (ready[0]) rdy_cnt0++;
        if (ready[1]) rdy_cnt1++;
        if (acc[0]) alog.push_back(0);
        if (acc[1]) alog.push_back(1);
        @(posedge clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        present();
    endtask

    task automatic run_until_done(input string tag, input int max);
        int k;
        k = 0;
        while (((en[0] && q0.size() > 0) || (en[1] && q1.size() > 0) || grant != '0) && k < max) begin
            cyc();
            k++;
        end
        chk(tag, 32'(k < max), 32'd1);
    endtask

    task automatic wait_strobes(input string tag, input int n, input int max);
        int k;
        k = 0;
        while (slog.size() < n && k < max) begin
            cyc();
            k++;
        end
        chk(tag, 32'(k < max), 32'd1);
    endtask

    task automatic clear_logs();
        slog.delete(); scyc.delete(); alog.delete();
        to_pulses = 0; rdy_cnt0 = 0; rdy_cnt1 = 0; dual_err = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wr"}, 32'(wr), 0);
        chk({tag, "_wrc"}, 32'(wrc), 0);
        chk({tag, "_data"}, 32'(dsend), 0);
        chk({tag, "_cmd"}, 32'(cmdo), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_timeout"}, 32'(to), 0);
    endtask

    initial begin
        int bad;
        int s;
        rst = 1'b1; tx_ready = 1'b1; en = 2'b00;
        present();
        repeat (3) cyc();
        chk_quiet("reset");

        // Two requesters valid straight after reset: req0 packet first, then req1.
        q0 = '{10'h011, 10'h022, 10'h133};
        q1 = '{10'h1A5};
        en = 2'b11;
        present();
        clear_logs();
        rst = 1'b0;
        #1;
        chk("first_idle_grant", 32'(grant), 0);
        chk("first_idle_ready", 32'(ready), 0);
        cyc();
        chk("first_hold_grant", 32'(grant), 32'h1);
        chk("first_hold_ready", 32'(ready), 32'h1);
        cyc();
        chk("first_strobe_wr", 32'(wr), 1);
        chk("first_strobe_data", 32'(dsend), 32'h11);
        run_until_done("pkt_done", 100);
        chk("pkt_count", slog.size(), 4);
        if (slog.size() == 4) begin
            chk("pkt_b0", 32'(slog[0]), 32'h011);
            chk("pkt_b1", 32'(slog[1]), 32'h022);
            chk("pkt_b2", 32'(slog[2]), 32'h033);
            chk("pkt_b3", 32'(slog[3]), 32'h0A5);
            chk("pkt_gap01", scyc[1] - scyc[0], 3);
            chk("pkt_gap12", scyc[2] - scyc[1], 3);
            chk("pkt_gap23", scyc[3] - scyc[2], 4);
            chk("pkt_owner_last", alog[3], 1);
        end
        $display("txn pkt: 11 22 33 A5 strobes=%0d", slog.size());

        // Single-byte command packet from req1.
        clear_logs();
        q1 = '{10'h2B1 | 10'h100};
        en = 2'b10;
        present();
        run_until_done("cmd_done", 50);
        chk("cmd_count", slog.size(), 1);
        if (slog.size() == 1) chk("cmd_byte", 32'(slog[0]), 32'h1B1);
        chk("cmd_port", 32'(cmdo), 32'hB1);
        chk("cmd_data_stable", 32'(dsend), 32'hA5);
        $display("txn cmd: B1 strobes=%0d", slog.size());

        // TX_READY_I low for 20 cycles after a strobe.
        clear_logs();
        q0 = '{10'h040, 10'h141};
        en = 2'b01;
        present();
        wait_strobes("stall_first", 1, 20);
        tx_ready = 1'b0;
        s = rdy_cnt0;
        repeat (20) cyc();
        chk("stall_no_ready", rdy_cnt0 - s, 0);
        chk("stall_no_strobe", slog.size(), 1);
        tx_ready = 1'b1;
        #1;
        chk("stall_rise_ready", 32'(ready), 0);
        cyc();
        chk("stall_accept", 32'(ready), 32'h1);
        run_until_done("stall_done", 50);
        chk("stall_count", slog.size(), 2);
        if (slog.size() == 2) chk("stall_b1", 32'(slog[1]), 32'h041);
        $display("txn stall: 40 41 strobes=%0d", slog.size());

        // Owner req0 goes silent mid-packet while req1 waits.
        clear_logs();
        q0 = '{10'h050};
        q1 = '{10'h160};
        en = 2'b01;
        present();
        wait_strobes("silent_first", 1, 20);
        s = scyc[0];
        en = 2'b11;
        present();
`ifdef UART_TX_ARB_TIMEOUT_EN
        wait_strobes("to_second", 2, 60);
        chk("to_pulses", to_pulses, 1);
        chk("to_latency", to_cyc - s, 18);
        if (slog.size() == 2) begin
            chk("to_req1_byte", 32'(slog[1]), 32'h060);
            chk("to_req1_time", scyc[1] - s, 20);
        end
        run_until_done("to_done", 20);
        $display("txn timeout: pulse at +%0d", to_cyc - s);
`else
        repeat (60) cyc();
        chk("starve_strobes", slog.size(), 1);
        chk("starve_grant", 32'(grant), 32'h1);
        chk("starve_req1_ready", rdy_cnt1, 0);
        chk("starve_timeout", to_pulses, 0);
        $display("txn starve: req1 held off, strobes=%0d", slog.size());
`endif
        rst = 1'b1;
        en = 2'b00; q0.delete(); q1.delete();
        present();
        repeat (2) cyc();
        rst = 1'b0;

        // Reset asserted for 2 cycles while a byte is in WAIT.
        clear_logs();
        q0 = '{10'h070, 10'h171};
        en = 2'b01;
        present();
        wait_strobes("rst_first", 1, 20);
        rst = 1'b1;
        q0.delete();
        present();
        #1;
        chk_quiet("rst_async");
        repeat (2) cyc();
        chk_quiet("rst_held");
        clear_logs();
        rst = 1'b0;
        q1 = '{10'h180};
        en = 2'b10;
        present();
        #1;
        chk("rst_idle_grant", 32'(grant), 0);
        cyc();
        chk("rst_grant", 32'(grant), 32'h2);
        cyc();
        chk("rst_strobe_wrc", 32'(wrc), 0);
        chk("rst_strobe_data", 32'(dsend), 32'h80);
        run_until_done("rst_done", 20);
        chk("rst_count", slog.size(), 1);
        $display("txn reset: 80 strobes=%0d", slog.size());

        // 100 single-byte packets from each requester.
        clear_logs();
        for (int i = 0; i < 100; i++) begin
            q0.push_back(10'h100 | 10'(i));
            q1.push_back(10'h180 | 10'(i));
        end
        en = 2'b11;
        present();
        run_until_done("alt_done", 1200);
        chk("alt_count", slog.size(), 200);
        bad = 0;
        for (int k = 0; k < slog.size(); k++) begin
            if (slog[k] !== ((k % 2 == 0) ? 9'(k / 2) : 9'(8'h80 | 8'(k / 2)))) bad++;
            if (k > 0 && scyc[k] - scyc[k-1] < 3) bad++;
        end
        chk("alt_order_rate", bad, 0);
        chk("alt_dual", dual_err, 0);
        $display("txn alternate: strobes=%0d order_errors=%0d", slog.size(), bad);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
